// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector.
// Mode encodings, default widths and the edge/mode match helper.
package edge_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    localparam int CNT_W_DEF = 8;

    // Width of an index that can address n items, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when a detected rise/fall is one the channel mode reports.
    function automatic logic edge_hit(
        input logic [1:0] mode,
        input logic       rise,
        input logic       fall
    );
        logic hit;
        hit = 1'b0;
        unique case (mode)
            EDGE_OFF:  hit = 1'b0;
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One detector channel: synchroniser, persistence filter, edge
// classification, event pulse, sticky flag and saturating counter.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             cnt_clr,
    output logic             pulse,
    output logic             level,
    output logic             sticky,
    output logic [CNT_W-1:0] cnt
);

    localparam int FW = idx_w(FILTER_LEN);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FW-1:0]          filt_q, filt_d;
    logic                   level_q, level_d;
    logic                   lvl_prev_q, lvl_prev_d;
    logic                   pulse_q, pulse_d;
    logic                   sticky_q, sticky_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic sync_s;
    logic rise;
    logic fall;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift and persistence filter on the synchronised bit.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], d};
        filt_d  = filt_q;
        level_d = level_q;
        if (sync_s == level_q) begin
            filt_d = '0;
        end else if (filt_q == F_LAST) begin
            level_d = sync_s;
            filt_d  = '0;
        end else begin
            filt_d = filt_q + 1'b1;
        end
    end

    // Edge classification against the previous level, mode-gated pulse.
    always_comb begin
        lvl_prev_d = level_q;
        rise       = level_q & ~lvl_prev_q;
        fall       = ~level_q & lvl_prev_q;
        pulse_d    = edge_hit(mode, rise, fall);
    end

    // Sticky flag (set beats clear) and saturating event counter.
    always_comb begin
        sticky_d = pulse_q | (sticky_q & ~clr);
        cnt_d    = cnt_q;
        if (cnt_clr) begin
            cnt_d = pulse_q ? CNT_ONE : '0;
        end else if (pulse_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Channel state registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            filt_q     <= '0;
            level_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
            pulse_q    <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            level_q    <= level_d;
            lvl_prev_q <= lvl_prev_d;
            pulse_q    <= pulse_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pulse  = pulse_q;
    assign level  = level_q;
    assign sticky = sticky_q;
    assign cnt    = cnt_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: CH independent channels plus counter
// read-back mux, counter-clear steering and interrupt reduction.
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = CNT_W_DEF,
    localparam int SEL_W      = idx_w(CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    d,
    input  logic [2*CH-1:0]  mode,
    input  logic [CH-1:0]    clr,
    input  logic [SEL_W-1:0] cnt_sel,
    input  logic             cnt_clr,
    output logic [CH-1:0]    pulse,
    output logic [CH-1:0]    level,
    output logic [CH-1:0]    sticky,
    output logic [CNT_W-1:0] cnt_rd,
    output logic             irq
);

    logic [CNT_W-1:0] chan_cnt [CH];
    logic [CH-1:0]    chan_clr;

    // Select a counter for read-back and steer the clear to it; an
    // out-of-range select reads zero and clears nothing.
    always_comb begin
        cnt_rd   = '0;
        chan_clr = '0;
        for (int i = 0; i < CH; i++) begin
            if (cnt_sel == SEL_W'(i)) begin
                cnt_rd      = chan_cnt[i];
                chan_clr[i] = cnt_clr;
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .d       (d[g]),
            .mode    (mode[2*g +: 2]),
            .clr     (clr[g]),
            .cnt_clr (chan_clr[g]),
            .pulse   (pulse[g]),
            .level   (level[g]),
            .sticky  (sticky[g]),
            .cnt     (chan_cnt[g])
        );
    end

    assign irq = |sticky;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench for multi_edge_detector (CH=4, CNT_W=2).
// Directed stimulus queues expected pulses; a monitor checks them.
module tb_multi_edge_detector;

    localparam int LAT = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [1:0] cnt_sel;
    logic       cnt_clr;
    logic [3:0] pulse;
    logic [3:0] level;
    logic [3:0] sticky;
    logic [1:0] cnt_rd;
    logic       irq;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } exp_t;

    exp_t sb_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    multi_edge_detector #(
        .CH          (4),
        .SYNC_STAGES (2),
        .FILTER_LEN  (4),
        .CNT_W       (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .mode    (mode),
        .clr     (clr),
        .cnt_sel (cnt_sel),
        .cnt_clr (cnt_clr),
        .pulse   (pulse),
        .level   (level),
        .sticky  (sticky),
        .cnt_rd  (cnt_rd),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_pulse(input logic [3:0] m);
        exp_t e;
        e.cyc  = cyc + LAT;
        e.mask = m;
        sb_q.push_back(e);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && pulse !== 4'b0000) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: got %b at cyc %0d",
                         pulse, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (pulse !== e.mask || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL pulse: got %b@%0d expected %b@%0d",
                             pulse, cyc, e.mask, e.cyc);
                end
            end
        end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missed_pulse: got none expected %b@%0d",
                     e.mask, e.cyc);
        end
    end

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst     = 1'b0;
        d       = '0;
        mode    = 8'b00_10_11_01;
        clr     = '0;
        cnt_sel = '0;
        cnt_clr = 1'b0;
        tick(3);
        chk("rst_pulse", pulse, 0);
        chk("rst_level", level, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_irq", irq, 0);
        chk("rst_cnt", cnt_rd, 0);
        rst = 1'b1;
        tick(3);

        // ch0 rising, mode 01
        d[0] = 1'b1;
        expect_pulse(4'b0001);
        tick(8);
        chk("c0_level", level, 4'b0001);
        chk("c0_sticky", sticky, 4'b0001);
        chk("c0_irq", irq, 1);
        chk("c0_cnt", cnt_rd, 1);

        // ch1 3-cycle glitch is rejected
        d[1] = 1'b1;
        tick(3);
        d[1] = 1'b0;
        tick(10);
        cnt_sel = 2'd1;
        #1;
        chk("c1_glitch_level", level, 4'b0001);
        chk("c1_glitch_cnt", cnt_rd, 0);

        // ch1 both edges, mode 11
        d[1] = 1'b1;
        expect_pulse(4'b0010);
        tick(8);
        chk("c1_rise_level", level, 4'b0011);
        chk("c1_rise_cnt", cnt_rd, 1);
        d[1] = 1'b0;
        expect_pulse(4'b0010);
        tick(8);
        chk("c1_fall_cnt", cnt_rd, 2);

        // ch2 fall-only, ch3 off: same stimulus
        d[3:2] = 2'b11;
        tick(8);
        chk("c23_rise_level", level, 4'b1101);
        d[3:2] = 2'b00;
        expect_pulse(4'b0100);
        tick(8);
        chk("c23_fall_level", level, 4'b0001);
        chk("c23_sticky", sticky, 4'b0111);
        cnt_sel = 2'd2;
        #1;
        chk("c2_cnt", cnt_rd, 1);
        cnt_sel = 2'd3;
        #1;
        chk("c3_cnt", cnt_rd, 0);

        clr = 4'b0110;
        tick(1);
        clr = '0;
        chk("clr12_sticky", sticky, 4'b0001);

        // clear coinciding with a new ch0 pulse: set wins
        d[0] = 1'b0;
        tick(8);
        d[0] = 1'b1;
        expect_pulse(4'b0001);
        tick(7);
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        chk("set_wins_sticky", sticky, 4'b0001);
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        chk("idle_clr_sticky", sticky, 4'b0000);
        chk("idle_clr_irq", irq, 0);

        // counter saturation on ch0 (CNT_W=2)
        cnt_sel = 2'd0;
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("cnt_clr", cnt_rd, 0);
        for (int k = 0; k < 5; k++) begin
            d[0] = 1'b0;
            tick(8);
            d[0] = 1'b1;
            expect_pulse(4'b0001);
            tick(8);
            chk($sformatf("sat_%0d", k), cnt_rd, sat_exp[k]);
        end
        d[0] = 1'b0;
        tick(8);
        d[0] = 1'b1;
        expect_pulse(4'b0001);
        tick(7);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("clr_with_pulse_cnt", cnt_rd, 1);

        // reset mid-filter, release with d[0] held high
        d[0] = 1'b0;
        tick(8);
        d[0] = 1'b1;
        tick(4);
        rst = 1'b0;
        #1;
        chk("mid_rst_pulse", pulse, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_sticky", sticky, 0);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_cnt", cnt_rd, 0);
        tick(3);
        rst = 1'b1;
        expect_pulse(4'b0001);
        tick(8);
        chk("post_rst_level", level, 4'b0001);
        chk("post_rst_sticky", sticky, 4'b0001);
        chk("post_rst_cnt", cnt_rd, 1);

        tick(10);
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised, multi-channel successor to the single-bit either-edge detector.
- Each channel provides:
  - a synchroniser for an asynchronous input
  - a glitch/debounce filter
  - per-channel edge-mode selection (off/rise/fall/both)
  - a one-cycle event pulse
  - a sticky status bit with write-1-to-clear
  - a saturating event counter
- Sits between raw external inputs (buttons, async status lines) and interrupt/status logic.

Parameters:
- CH, 4: number of independent channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- FILTER_LEN, 4: consecutive cycles a new synchronised value must persist before it is accepted (≥1; 1 = no filtering).
- CNT_W, 8: width of each per-channel event counter (≥1).

Ports:
- clk  in  1  rising-edge clock for all state.
- rst  in  1  asynchronous, active-low reset; clears all state.
- d  in  CH  raw asynchronous inputs, one bit per channel.
- mode  in  2*CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- clr  in  CH  sticky clear, write-1-to-clear, per channel.
- cnt_sel  in  max(1,$clog2(CH))  selects the counter shown on cnt_rd.
- cnt_clr  in  1  clears the counter selected by cnt_sel.
- pulse  out  CH  one-cycle event strobe per channel.
- level  out  CH  filtered, synchronised level per channel.
- sticky  out  CH  latched event flags.
- cnt_rd  out  CNT_W  value of the selected counter (combinational mux).
- irq  out  1  OR-reduction of sticky.

Behaviour:
- Reset (rst=0, asynchronous) forces the following to 0: sync flops, filter counters, level, pulse, sticky, counters. Consequently irq=0 and cnt_rd=0.
- Synchroniser: s_i is the last of SYNC_STAGES flops clocked from d[i].
- Filter, per channel, a count f, evaluated on each clock edge:
  - If s_i == level[i]: f←0.
  - Else if f == FILTER_LEN-1: level[i]←s_i and f←0.
  - Else: f←f+1.
  - Any return to agreement before acceptance discards the candidate.
- Edge classification uses the registered level and its previous value:
  - rise = level & ~level_d
  - fall = ~level & level_d
- pulse[i] is registered. It is 1 for exactly one cycle, in the cycle after level[i] changes, when the change matches mode[i]:
  - 01 → rise only
  - 10 → fall only
  - 11 → either
  - 00 → never
- Latency: d[i] stable from before clock edge 0 → pulse[i] high between edges SYNC_STAGES+FILTER_LEN and SYNC_STAGES+FILTER_LEN+1. With defaults this is edge 6 to edge 7.
- Mode changes take effect for the next level change. level and the filter always run regardless of mode.
- sticky[i]:
  - Set on pulse[i].
  - Cleared on clr[i]=1.
  - Simultaneous set and clear → set wins.
- Counter[i]:
  - Increments on pulse[i].
  - Saturates at 2^CNT_W−1 and does not wrap.
  - cnt_clr clears counter[cnt_sel].
  - Simultaneous cnt_clr and pulse on the same channel → counter=1.
- cnt_rd = counter[cnt_sel]. If cnt_sel ≥ CH, cnt_rd=0 and cnt_clr is ignored.
- A d input held high through reset release produces a rising event after the normal latency, because level resets to 0.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.

Decomposition:
- Shared package edge_pkg holds:
  - mode constants EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11
  - CNT_W default
- Sub-module edge_chan implements one channel: synchroniser, filter, edge detection, pulse, sticky, counter. It exposes its counter value.
- multi_edge_detector generates CH edge_chan instances. It also performs cnt_sel decode/mux, cnt_clr steering, and the irq OR-reduction.

Test Plan:
- Defaults, mode[1:0]=01, d[0] rises before edge 0 → level[0] rises after edge 5, pulse[0]=1 for one cycle after edge 6, sticky[0]=1, irq=1, counter0=1.
- d[1] high for 3 cycles then low, FILTER_LEN=4, mode=11 → level[1] stays 0, no pulse, counter1=0. Then hold d[1] high ≥4 cycles → one pulse.
- Channel 2 in mode 10, a full rise/fall cycle on d[2] → exactly one pulse, on the fall. Channel 3 in mode 00, same stimulus → level[3] toggles but there is no pulse, sticky or count.
- clr[0]=1 in the same cycle as a new pulse[0] → sticky[0] stays 1. clr[0]=1 in a later idle cycle → sticky[0]=0, irq=0.
- CNT_W=2, 5 events on channel 0 → cnt_rd (cnt_sel=0) reads 1, 2, 3, 3, 3. Then cnt_clr coinciding with a pulse → reads 1.
- Assert rst mid-filter (f=2) with d[0]=1 → all outputs 0 immediately. Release rst with d[0] still high → rising pulse exactly 6 cycles after the first clock edge following release.
